// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Purpose:
//   Instruction fetch front end. A four-state FSM (IDLE, REQ, STEP, DRAIN)
//   keeps at most one instruction-memory request outstanding. Returned words
//   go into a 2-entry FIFO that feeds the decoder. The PC stage is told to
//   advance with a one-cycle pulse after each accepted fetch. A redirect
//   (flush) empties the FIFO and causes any in-flight request's data to be
//   dropped.
//
// Optional feature:
//   FETCH_PERF_EN - when defined, stall_cnt counts cycles in which the decoder
//                   is ready but no instruction is available. The counter
//                   saturates at 0xFFFF. When undefined, stall_cnt is tied to 0.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   pc_in      in   [DWIDTH] current program counter from the PC stage
//   pc_adv     out  one-cycle increment pulse to the PC stage
//   flush      in   branch/redirect; discards buffered and in-flight words
//   mem_req    out  instruction memory request
//   mem_addr   out  [DWIDTH] request address, stable while mem_req=1
//   mem_ack    in   memory completion; mem_rdata is valid in the same cycle
//   mem_rdata  in   [DWIDTH] fetched instruction word
//   ir_out     out  [DWIDTH] instruction at the FIFO head
//   ir_valid   out  ir_out is valid (FIFO not empty)
//   ir_ready   in   decoder accepts ir_out this cycle
//   stall_cnt  out  [16] stall performance counter
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter int DWIDTH = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DWIDTH-1:0] pc_in,
   output logic              pc_adv,
   input  logic              flush,
   output logic              mem_req,
   output logic [DWIDTH-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DWIDTH-1:0] mem_rdata,
   output logic [DWIDTH-1:0] ir_out,
   output logic              ir_valid,
   input  logic              ir_ready,
   output logic [15:0]       stall_cnt
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_STEP  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t            r_state;
   logic              r_mem_req;
   logic [DWIDTH-1:0] r_mem_addr;
   logic              r_pc_adv;

   logic [1:0]        r_count;
   logic [DWIDTH-1:0] r_ent [0:1];

   logic              w_push;
   logic              w_pop;

   // Only a completed, non-flushed request in REQ delivers data. An ack that
   // arrives in IDLE (after a reset abandoned the request) or in DRAIN is
   // ignored.
   assign w_push = (r_state == S_REQ) && mem_ack && !flush;
   assign w_pop  = ir_valid && ir_ready;

   // ---------------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_mem_req  <= 1'b0;
         r_mem_addr <= '0;
         r_pc_adv   <= 1'b0;
      end else begin
         r_pc_adv <= 1'b0;
         case (r_state)
            S_IDLE: begin
               // A request is issued only when the FIFO has space for its
               // data. With one request outstanding, the FIFO can never
               // overflow.
               if (!flush && (r_count < 2'd2)) begin
                  r_state    <= S_REQ;
                  r_mem_req  <= 1'b1;
                  r_mem_addr <= pc_in;
               end
            end
            S_REQ: begin
               if (mem_ack) begin
                  r_mem_req <= 1'b0;
                  if (flush) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_state  <= S_STEP;
                     r_pc_adv <= 1'b1;
                  end
               end else if (flush) begin
                  // The memory still owes a response. Keep the request up
                  // and throw the data away when it arrives.
                  r_state <= S_DRAIN;
               end
            end
            S_STEP: begin
               r_state <= S_IDLE;
            end
            S_DRAIN: begin
               if (mem_ack) begin
                  r_mem_req <= 1'b0;
                  r_state   <= S_IDLE;
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_mem_req <= 1'b0;
            end
         endcase
      end
   end

   assign mem_req  = r_mem_req;
   assign mem_addr = r_mem_addr;

   // The pulse is registered on entry to STEP. A flush in the STEP cycle
   // itself must still cancel the pulse, so flush gates the output directly.
   assign pc_adv = r_pc_adv && !flush;

   // ---------------------------------------------------------------------
   // 2-entry FIFO. This is a shift structure, so the head is always r_ent[0].
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count  <= 2'd0;
         r_ent[0] <= '0;
         r_ent[1] <= '0;
      end else if (flush) begin
         // flush takes precedence over any same-cycle push or pop
         r_count <= 2'd0;
      end else begin
         case ({w_push, w_pop})
            2'b11: begin
               // Simultaneous push and pop: the occupancy is unchanged.
               if (r_count == 2'd2) begin
                  r_ent[0] <= r_ent[1];
                  r_ent[1] <= mem_rdata;
               end else begin
                  r_ent[0] <= mem_rdata;
               end
            end
            2'b10: begin
               // The write slot equals the current count (0 or 1).
               r_ent[r_count[0]] <= mem_rdata;
               r_count           <= r_count + 2'd1;
            end
            2'b01: begin
               r_ent[0] <= r_ent[1];
               r_count  <= r_count - 2'd1;
            end
            default: begin
            end
         endcase
      end
   end

   assign ir_valid = (r_count != 2'd0);
   assign ir_out   = r_ent[0];

   // ---------------------------------------------------------------------
   // Stall performance counter
   // ---------------------------------------------------------------------
`ifdef FETCH_PERF_EN
   logic [15:0] r_stall_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= 16'd0;
      end else if (!ir_valid && ir_ready && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`else
   assign stall_cnt = 16'd0;
`endif

endmodule
